// File: rtl/atm_keypad_ctrl_pkg.sv
// Shared definitions for the ATM keypad front end.
// Holds the FSM state encoding, keypad key codes, operation codes and a digit helper.
package atm_keypad_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LANG_SEL    = 3'd1,
    ST_PSW_ENTRY   = 3'd2,
    ST_PSW_WAIT    = 3'd3,
    ST_OP_SEL      = 3'd4,
    ST_VAL_ENTRY   = 3'd5,
    ST_RESP_WAIT   = 3'd6,
    ST_ASK_ANOTHER = 3'd7
  } state_t;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hC;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_TRF = 2'b11;

  // True for keys 0-9.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= KEY_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// Decimal accumulator: next_val = acc*10 + digit, evaluated W+4 bits wide.
// Ports: acc (current value), digit (new BCD digit), next_val (low W bits of the
// result), overflow (result does not fit in W bits).
module atm_dec_accum #(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] next_val,
  output logic         overflow
);

  localparam int unsigned WW = W + 4;

  logic [WW-1:0] wide;

  // acc*10 + 9 < 16*2^W, so four extra bits never wrap.
  always_comb begin
    wide     = WW'(acc) * WW'(10) + WW'(digit);
    next_val = wide[W-1:0];
    overflow = |wide[WW-1:W];
  end

endmodule

// File: rtl/atm_keypad_ctrl.sv
// ATM customer-side keypad controller.
// Turns keypad strokes into language, BCD password, operation and binary value,
// issues one-cycle submit strobes and tracks the core's responses.
// Inputs : clk, rst (async, high), card_present, key_valid/key_code, op_done,
//          error, wrong_psw.
// Outputs: language, password_input, psw_valid, operation, value, cmd_valid,
//          another_service, entry_err, card_eject, card_retain, busy (all registered).
module atm_keypad_ctrl
  import atm_keypad_ctrl_pkg::*;
#(
  parameter int unsigned password_width = 16,
  parameter int unsigned balance_width  = 20,
  parameter int unsigned max_tries      = 3,
  parameter int unsigned psw_wait_cyc   = 4,
  parameter int unsigned resp_timeout   = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_present,
  input  logic                      key_valid,
  input  logic [3:0]                key_code,
  input  logic                      op_done,
  input  logic                      error,
  input  logic                      wrong_psw,
  output logic                      language,
  output logic [password_width-1:0] password_input,
  output logic                      psw_valid,
  output logic [1:0]                operation,
  output logic [balance_width-1:0]  value,
  output logic                      cmd_valid,
  output logic                      another_service,
  output logic                      entry_err,
  output logic                      card_eject,
  output logic                      card_retain,
  output logic                      busy
);

  localparam int unsigned PSW_DIGITS = password_width / 4;
  localparam int unsigned CNT_W      = $clog2(PSW_DIGITS + 1);
  localparam int unsigned TRY_W      = $clog2(max_tries + 1);
  localparam int unsigned TMR_MAX    = (resp_timeout > psw_wait_cyc) ? resp_timeout : psw_wait_cyc;
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

  state_t                   state;
  logic                     card_q;
  logic [CNT_W-1:0]         dcnt;
  logic [TRY_W-1:0]         tries;
  logic [TMR_W-1:0]         timer;
  logic [balance_width-1:0] value_next_c;
  logic                     value_ovf_c;
  logic                     cancel_hit_c;
  logic                     digit_c;

  atm_dec_accum #(.W(balance_width)) u_accum (
    .acc      (value),
    .digit    (key_code),
    .next_val (value_next_c),
    .overflow (value_ovf_c)
  );

  // Cancel is honoured in every entry state and in the another-service prompt.
  always_comb begin
    digit_c      = is_digit(key_code);
    cancel_hit_c = key_valid && (key_code == KEY_CANCEL) &&
                   ((state == ST_LANG_SEL) || (state == ST_PSW_ENTRY) ||
                    (state == ST_OP_SEL)   || (state == ST_VAL_ENTRY) ||
                    (state == ST_ASK_ANOTHER));
  end

  // Session FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      card_q          <= 1'b0;
      dcnt            <= '0;
      tries           <= '0;
      timer           <= '0;
      language        <= 1'b0;
      password_input  <= '0;
      psw_valid       <= 1'b0;
      operation       <= OP_INQ;
      value           <= '0;
      cmd_valid       <= 1'b0;
      another_service <= 1'b0;
      entry_err       <= 1'b0;
      card_eject      <= 1'b0;
      card_retain     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      card_q      <= card_present;
      psw_valid   <= 1'b0;
      cmd_valid   <= 1'b0;
      entry_err   <= 1'b0;
      card_eject  <= 1'b0;
      card_retain <= 1'b0;

      // Card removal beats any keystroke in the same cycle and ejects nothing.
      if ((state != ST_IDLE) && !card_present) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (cancel_hit_c) begin
        if (state == ST_ASK_ANOTHER) another_service <= 1'b0;
        state      <= ST_IDLE;
        busy       <= 1'b0;
        card_eject <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (card_present && !card_q) begin
              state           <= ST_LANG_SEL;
              busy            <= 1'b1;
              password_input  <= '0;
              value           <= '0;
              another_service <= 1'b0;
              tries           <= '0;
              dcnt            <= '0;
            end
          end

          ST_LANG_SEL: begin
            if (key_valid) begin
              if (key_code == 4'd1) begin
                language <= 1'b0;
                state    <= ST_PSW_ENTRY;
              end else if (key_code == 4'd2) begin
                language <= 1'b1;
                state    <= ST_PSW_ENTRY;
              end else begin
                entry_err <= 1'b1;
              end
            end
          end

          ST_PSW_ENTRY: begin
            if (key_valid) begin
              if (digit_c) begin
                if (dcnt == CNT_W'(PSW_DIGITS)) begin
                  entry_err <= 1'b1;
                end else begin
                  password_input <= {password_input[password_width-5:0], key_code};
                  dcnt           <= dcnt + CNT_W'(1);
                end
              end else if (key_code == KEY_ENTER) begin
                if (dcnt == CNT_W'(PSW_DIGITS)) begin
                  psw_valid <= 1'b1;
                  timer     <= '0;
                  state     <= ST_PSW_WAIT;
                end else begin
                  entry_err <= 1'b1;
                end
              end else if (key_code == KEY_CLEAR) begin
                password_input <= '0;
                dcnt           <= '0;
              end
            end
          end

          // Silence for psw_wait_cyc cycles means the core accepted the password.
          ST_PSW_WAIT: begin
            if (wrong_psw) begin
              if ((tries + TRY_W'(1)) == TRY_W'(max_tries)) begin
                tries       <= tries + TRY_W'(1);
                card_retain <= 1'b1;
                busy        <= 1'b0;
                state       <= ST_IDLE;
              end else begin
                tries          <= tries + TRY_W'(1);
                password_input <= '0;
                dcnt           <= '0;
                state          <= ST_PSW_ENTRY;
              end
            end else if (timer == TMR_W'(psw_wait_cyc - 1)) begin
              state <= ST_OP_SEL;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          ST_OP_SEL: begin
            if (key_valid && digit_c) begin
              if (key_code == 4'd1) begin
                operation <= OP_INQ;
                value     <= '0;
                cmd_valid <= 1'b1;
                timer     <= '0;
                state     <= ST_RESP_WAIT;
              end else if ((key_code >= 4'd2) && (key_code <= 4'd4)) begin
                operation <= 2'(key_code - 4'd1);
                value     <= '0;
                state     <= ST_VAL_ENTRY;
              end else begin
                entry_err <= 1'b1;
              end
            end
          end

          ST_VAL_ENTRY: begin
            if (key_valid) begin
              if (digit_c) begin
                if (value_ovf_c) entry_err <= 1'b1;
                else             value     <= value_next_c;
              end else if (key_code == KEY_ENTER) begin
                if (value == '0) begin
                  entry_err <= 1'b1;
                end else begin
                  cmd_valid <= 1'b1;
                  timer     <= '0;
                  state     <= ST_RESP_WAIT;
                end
              end else if (key_code == KEY_CLEAR) begin
                value <= '0;
              end
            end
          end

          // op_done and error lead to the same prompt, so both are one condition.
          ST_RESP_WAIT: begin
            if (op_done || error) begin
              state <= ST_ASK_ANOTHER;
            end else if (timer == TMR_W'(resp_timeout - 1)) begin
              card_eject <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          ST_ASK_ANOTHER: begin
            if (key_valid && (key_code == KEY_ENTER)) begin
              another_service <= 1'b1;
              state           <= ST_OP_SEL;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_ctrl.sv
// Directed self-checking bench for atm_keypad_ctrl (resp_timeout shortened to 16).
module tb_atm_keypad_ctrl;
  import atm_keypad_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_present;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        op_done;
  logic        error;
  logic        wrong_psw;
  logic        language;
  logic [15:0] password_input;
  logic        psw_valid;
  logic [1:0]  operation;
  logic [19:0] value;
  logic        cmd_valid;
  logic        another_service;
  logic        entry_err;
  logic        card_eject;
  logic        card_retain;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atm_keypad_ctrl #(
    .password_width (16),
    .balance_width  (20),
    .max_tries      (3),
    .psw_wait_cyc   (4),
    .resp_timeout   (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .card_present    (card_present),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .op_done         (op_done),
    .error           (error),
    .wrong_psw       (wrong_psw),
    .language        (language),
    .password_input  (password_input),
    .psw_valid       (psw_valid),
    .operation       (operation),
    .value           (value),
    .cmd_valid       (cmd_valid),
    .another_service (another_service),
    .entry_err       (entry_err),
    .card_eject      (card_eject),
    .card_retain     (card_retain),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(dut.state), 32'(exp));
  endtask

  // All tasks start and end on a falling edge.
  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic core(input logic od, input logic er, input logic wp);
    op_done   = od;
    error     = er;
    wrong_psw = wp;
    @(negedge clk);
    op_done   = 1'b0;
    error     = 1'b0;
    wrong_psw = 1'b0;
  endtask

  task automatic card_in();
    card_present = 1'b0;
    @(negedge clk);
    card_present = 1'b1;
    @(negedge clk);
  endtask

  task automatic to_op_sel();
    card_in();
    key(4'd1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(KEY_ENTER);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; card_present = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    op_done = 1'b0; error = 1'b0; wrong_psw = 1'b0;
    repeat (2) @(negedge clk);
    chk_st("rst_state", ST_IDLE);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_psw", 32'(password_input), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_strobes", 32'({psw_valid, cmd_valid, entry_err, card_eject, card_retain}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_st("idle_after_rst", ST_IDLE);

    // Card in, English, password 1234, accepted after the 4-cycle window.
    card_present = 1'b1;
    @(negedge clk);
    chk_st("lang_sel", ST_LANG_SEL);
    chk("busy_on", 32'(busy), 32'd1);
    key(4'd1);
    chk("lang_en", 32'(language), 32'd0);
    chk_st("psw_entry", ST_PSW_ENTRY);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("psw_1234", 32'(password_input), 32'h1234);
    key(KEY_ENTER);
    chk("psw_valid_pulse", 32'(psw_valid), 32'd1);
    chk_st("psw_wait", ST_PSW_WAIT);
    repeat (3) @(negedge clk);
    chk("psw_valid_once", 32'(psw_valid), 32'd0);
    chk_st("psw_wait_3", ST_PSW_WAIT);
    @(negedge clk);
    chk_st("op_sel_after_4", ST_OP_SEL);

    // Inquiry, simultaneous op_done+error, another service.
    key(4'd1);
    chk("inq_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("inq_op", 32'(operation), 32'(OP_INQ));
    chk("inq_value", 32'(value), 32'd0);
    chk_st("inq_resp_wait", ST_RESP_WAIT);
    core(1'b1, 1'b1, 1'b0);
    chk_st("ask_after_both", ST_ASK_ANOTHER);
    key(KEY_ENTER);
    chk("another_1", 32'(another_service), 32'd1);
    chk_st("op_sel_again", ST_OP_SEL);

    // Withdraw with an overflowing 7th digit.
    key(4'd3);
    chk_st("val_entry", ST_VAL_ENTRY);
    chk("wdr_op", 32'(operation), 32'(OP_WDR));
    key(4'd1); key(4'd0); key(4'd4); key(4'd8); key(4'd5); key(4'd7);
    chk("val_104857", 32'(value), 32'd104857);
    chk("no_err_yet", 32'(entry_err), 32'd0);
    key(4'd6);
    chk("ovf_err", 32'(entry_err), 32'd1);
    chk("ovf_hold", 32'(value), 32'd104857);
    key(KEY_ENTER);
    chk("wdr_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("wdr_op_out", 32'(operation), 32'(OP_WDR));
    core(1'b1, 1'b0, 1'b0);
    chk_st("ask_after_done", ST_ASK_ANOTHER);
    key(KEY_CANCEL);
    chk("cancel_eject", 32'(card_eject), 32'd1);
    chk("cancel_another", 32'(another_service), 32'd0);
    chk_st("cancel_idle", ST_IDLE);
    chk("cancel_busy", 32'(busy), 32'd0);

    // Three wrong passwords retain the card.
    card_in();
    key(4'd2);
    chk("lang_2", 32'(language), 32'd1);
    key(KEY_ENTER);
    chk("short_enter_err", 32'(entry_err), 32'd1);
    for (int r = 0; r < 3; r++) begin
      if (r == 1) begin
        key(4'd9);
        key(KEY_CLEAR);
        chk("clear_psw", 32'(password_input), 32'd0);
      end
      key(4'd5); key(4'd6); key(4'd7); key(4'd8);
      if (r == 0) begin
        key(4'd9);
        chk("fifth_digit_err", 32'(entry_err), 32'd1);
        chk("fifth_digit_hold", 32'(password_input), 32'h5678);
      end
      key(KEY_ENTER);
      chk("retry_psw_valid", 32'(psw_valid), 32'd1);
      core(1'b0, 1'b0, 1'b1);
      if (r < 2) begin
        chk_st("retry_psw_entry", ST_PSW_ENTRY);
        chk("retry_psw_clr", 32'(password_input), 32'd0);
        chk("retry_no_retain", 32'(card_retain), 32'd0);
      end else begin
        chk("retain_pulse", 32'(card_retain), 32'd1);
        chk("retain_no_eject", 32'(card_eject), 32'd0);
        chk_st("retain_idle", ST_IDLE);
        chk("retain_busy", 32'(busy), 32'd0);
      end
    end
    @(negedge clk);
    chk("retain_once", 32'(card_retain), 32'd0);

    // Card pulled together with a digit in VAL_ENTRY.
    to_op_sel();
    key(4'd4);
    chk("trf_op", 32'(operation), 32'(OP_TRF));
    key(4'd5);
    chk("val_5", 32'(value), 32'd5);
    card_present = 1'b0;
    key(4'd7);
    chk_st("pull_idle", ST_IDLE);
    chk("pull_value", 32'(value), 32'd5);
    chk("pull_no_eject", 32'(card_eject), 32'd0);
    chk("pull_busy", 32'(busy), 32'd0);

    // Response timeout.
    to_op_sel();
    key(4'd1);
    chk("to_cmd_valid", 32'(cmd_valid), 32'd1);
    repeat (15) @(negedge clk);
    chk_st("to_still_wait", ST_RESP_WAIT);
    chk("to_no_eject_15", 32'(card_eject), 32'd0);
    @(negedge clk);
    chk("to_eject_16", 32'(card_eject), 32'd1);
    chk_st("to_idle", ST_IDLE);
    chk("to_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-session.
    card_in();
    chk_st("arst_lang", ST_LANG_SEL);
    #2 rst = 1'b1;
    #1;
    chk_st("arst_idle", ST_IDLE);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_no_strobe", 32'({psw_valid, cmd_valid, entry_err, card_eject, card_retain}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_keypad_ctrl.md
Name: atm_keypad_ctrl

Overview:
- Customer-side front end that drives the ATM transaction core's user inputs.
- Collects keypad strokes and builds the BCD password, language, operation and binary value.
- Issues one-cycle submit strobes, then waits for the core's op_done, error and wrong_psw responses.
- Sits between the keypad scanner and the ATM top-level inputs.

Parameters:
- password_width, 16, BCD password width; 4 bits per digit, so PSW_DIGITS = password_width/4.
- balance_width, 20, binary width of value.
- max_tries, 3, wrong-password attempts allowed before the card is retained.
- psw_wait_cyc, 4, cycles allowed for a wrong_psw response after password submit.
- resp_timeout, 1024, cycles allowed for op_done/error after a command submit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- card_present  in  1  card detected (level).
- key_valid  in  1  one-cycle keystroke strobe.
- key_code  in  4  0-9 digit, A enter, B clear, C cancel, D-F ignored.
- op_done  in  1  core pulse: operation completed.
- error  in  1  core pulse: operation rejected.
- wrong_psw  in  1  core pulse: password mismatch.
- language  out  1  0 = English, 1 = second language.
- password_input  out  password_width  BCD password; the newest digit is in the low nibble.
- psw_valid  out  1  one-cycle password submit strobe.
- operation  out  2  00 inquiry, 01 deposit, 10 withdraw, 11 transfer.
- value  out  balance_width  binary amount.
- cmd_valid  out  1  one-cycle command submit strobe.
- another_service  out  1  level; 1 = customer requested another service.
- entry_err  out  1  one-cycle pulse on a rejected keystroke.
- card_eject  out  1  one-cycle pulse: session ended normally or cancelled.
- card_retain  out  1  one-cycle pulse: too many wrong passwords.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, digit counter 0, tries counter 0, timers 0.
- All outputs are registered. A strobe is asserted the cycle after its causing keystroke or state transition.
- Keystrokes arriving outside an entry state are dropped silently.
- States: IDLE, LANG_SEL, PSW_ENTRY, PSW_WAIT, OP_SEL, VAL_ENTRY, RESP_WAIT, ASK_ANOTHER.
- IDLE:
  - Rising edge of card_present -> LANG_SEL; clears password_input, value, another_service and tries.
- LANG_SEL:
  - Digit 1 -> language=0; digit 2 -> language=1; both go to PSW_ENTRY.
  - Any other key except cancel -> entry_err.
- PSW_ENTRY:
  - Digit: shift into password_input and increment the count.
  - A fifth digit (PSW_DIGITS+1) -> entry_err; password unchanged.
  - Enter with count == PSW_DIGITS -> psw_valid pulse, PSW_WAIT. Enter with a short count -> entry_err.
  - Clear -> password and count zeroed.
- PSW_WAIT:
  - wrong_psw within psw_wait_cyc cycles -> tries+1.
  - If tries reaches max_tries: card_retain pulse, IDLE. Otherwise PSW_ENTRY with password cleared.
  - Timer expiry with no wrong_psw -> OP_SEL.
- OP_SEL:
  - Digits 1-4 map to operation 00-11. Digit 1 (inquiry) -> cmd_valid with value=0, then RESP_WAIT.
  - Digits 2-4 -> VAL_ENTRY with value cleared. Any other digit -> entry_err.
- VAL_ENTRY:
  - Digit d: next = value*10+d, computed at balance_width+4 bits.
  - If next > 2^balance_width-1 -> entry_err and value held. Otherwise value=next.
  - Enter with value==0 -> entry_err. Enter with value>0 -> cmd_valid, RESP_WAIT.
  - Clear -> value=0.
- RESP_WAIT:
  - op_done or error -> ASK_ANOTHER. Simultaneous op_done and error are treated as error; the outcome is identical.
  - Keys are ignored here. resp_timeout expiry -> card_eject, IDLE.
- ASK_ANOTHER:
  - Enter -> another_service=1, OP_SEL.
  - Cancel -> another_service=0, card_eject, IDLE.
- Cancel in LANG_SEL, PSW_ENTRY, OP_SEL or VAL_ENTRY -> card_eject, IDLE.
- card_present falling in any non-IDLE state -> IDLE immediately; no eject pulse; this has priority over any keystroke in the same cycle.
- Asynchronous reset mid-session -> IDLE, with no strobe emitted.

Decomposition:
- Shared package holds:
  - state encoding;
  - key-code constants: KEY_ENTER=4'hA, KEY_CLEAR=4'hB, KEY_CANCEL=4'hC;
  - operation codes OP_INQ, OP_DEP, OP_WDR, OP_TRF.
- One sub-module, atm_dec_accum: the value*10+d accumulator with its overflow flag, kept purely combinational.

Test Plan:
- Card in; keys 1, 1, 2, 3, 4, A; no wrong_psw -> language=0, password_input=16'h1234, one psw_valid pulse, OP_SEL reached 4 cycles later.
- Three rounds of 4-digit password + enter, each answered with a wrong_psw pulse -> card_retain pulses once after the third; state IDLE; no eject.
- In VAL_ENTRY (op 2) enter 1,0,4,8,5,7,6 -> value=1048576 is rejected: entry_err on the 7th digit, value stays 104857; enter -> cmd_valid with operation=10.
- Inquiry (digit 1) -> cmd_valid with value=0; inject op_done and error in the same cycle -> ASK_ANOTHER; enter -> another_service=1, OP_SEL.
- card_present drops during VAL_ENTRY at the same cycle as a digit keystroke -> IDLE, value not updated, card_eject stays 0.
- RESP_WAIT with no response for resp_timeout cycles (set to 16 in the bench) -> card_eject at cycle 16, IDLE, busy=0.
